// File: rtl/tipi_rpi_master.sv
// Pi-side initiator of the TIPI serial register link.
// Turns one-byte register commands into r_clk/r_le/r_rt/r_cd/r_dout
// sequences and samples r_din; stands in for the Raspberry Pi on-chip.
module tipi_rpi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_ctrl,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_parity_err,
    output logic       busy,
    output logic       r_clk,
    output logic       r_cd,
    output logic       r_dout,
    output logic       r_le,
    output logic       r_rt,
    input  logic       r_din,
    input  logic       r_reset
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        LATCH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   div_cnt, div_d;
    logic [2:0]         bit_cnt, bit_d;
    logic               clk_d;
    logic               is_write, is_write_d;
    logic [7:0]         wdata, wdata_d;
    logic [7:0]         rshift, rshift_d;
    logic [7:0]         rsp_rdata_d;
    logic               parity_d;
    logic               r_rt_d, r_cd_d, r_le_d, r_dout_d;
    logic               busy_d, rsp_valid_d;
    logic               accept, half_end, pulse_end;

    assign cmd_ready = (state == IDLE) & r_reset;
    assign accept    = cmd_valid & cmd_ready;
    assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    // last clk cycle of a high phase: r_din sample point and pulse boundary
    assign pulse_end = r_clk & half_end;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= 3'd0;
            r_clk          <= 1'b0;
            is_write       <= 1'b0;
            wdata          <= 8'h00;
            rshift         <= 8'h00;
            rsp_rdata      <= 8'h00;
            rsp_parity_err <= 1'b0;
            r_rt           <= 1'b0;
            r_cd           <= 1'b0;
            r_le           <= 1'b0;
            r_dout         <= 1'b0;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
        end else begin
            state          <= state_d;
            div_cnt        <= div_d;
            bit_cnt        <= bit_d;
            r_clk          <= clk_d;
            is_write       <= is_write_d;
            wdata          <= wdata_d;
            rshift         <= rshift_d;
            rsp_rdata      <= rsp_rdata_d;
            rsp_parity_err <= parity_d;
            r_rt           <= r_rt_d;
            r_cd           <= r_cd_d;
            r_le           <= r_le_d;
            r_dout         <= r_dout_d;
            busy           <= busy_d;
            rsp_valid      <= rsp_valid_d;
        end
    end

    // Next state, half-period divider, link clock and bit counter
    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        clk_d   = r_clk;
        case (state)
            IDLE: begin
                div_d = '0;
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                if (half_end) begin
                    div_d = '0;
                    if (is_write) begin
                        state_d = SHIFT;
                        bit_d   = bit_cnt - 3'd1;  // 0 -> 7 on entry to SHIFT
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            LOAD, SHIFT, LATCH: begin
                if (half_end) begin
                    div_d = '0;
                    clk_d = ~r_clk;
                    if (r_clk) begin
                        case (state)
                            LOAD: begin
                                state_d = SHIFT;
                                bit_d   = bit_cnt - 3'd1;
                            end
                            SHIFT: begin
                                if (bit_cnt == 3'd0) state_d = is_write ? LATCH : DONE;
                                else                 bit_d   = bit_cnt - 3'd1;
                            end
                            default: state_d = DONE;
                        endcase
                    end
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // TI-side link reset aborts any transfer at the next edge
        if (!r_reset && (state != IDLE)) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = 3'd0;
            clk_d   = 1'b0;
        end
    end

    // Next values of captured command, shift data and link/response outputs
    always_comb begin
        is_write_d  = is_write;
        wdata_d     = wdata;
        rshift_d    = rshift;
        rsp_rdata_d = rsp_rdata;
        parity_d    = rsp_parity_err;
        r_rt_d      = r_rt;
        r_cd_d      = r_cd;
        if (accept) begin
            is_write_d = cmd_write;
            wdata_d    = cmd_wdata;
            r_rt_d     = ~cmd_write;
            r_cd_d     = ~cmd_ctrl;
            parity_d   = 1'b0;
        end
        if (pulse_end && (state == SHIFT) && !is_write)
            rshift_d = {rshift[6:0], r_din};
        if (pulse_end && (state == LATCH))
            parity_d = (r_din != ^wdata);
        if ((state_d == DONE) && !is_write)
            rsp_rdata_d = rshift_d;
        r_le_d      = (state_d == LOAD) || (state_d == LATCH);
        r_dout_d    = (state_d == SHIFT) && is_write && wdata[bit_d];
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_tipi_rpi_master.sv
// Directed bench for tipi_rpi_master: one instance at CLK_DIV=4, one at
// CLK_DIV=1, each paired with a small behavioural TI-side register model.
module tb_tipi_rpi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance a: CLK_DIV = 4
    logic       a_reset, a_cmd_valid, a_cmd_ready, a_cmd_write, a_cmd_ctrl;
    logic [7:0] a_cmd_wdata, a_rsp_rdata;
    logic       a_rsp_valid, a_perr, a_busy;
    logic       a_r_clk, a_r_cd, a_r_dout, a_r_le, a_r_rt, a_r_reset;
    logic       a_r_din = 1'b0;

    // instance b: CLK_DIV = 1
    logic       b_reset, b_cmd_valid, b_cmd_ready, b_cmd_write, b_cmd_ctrl;
    logic [7:0] b_cmd_wdata, b_rsp_rdata;
    logic       b_rsp_valid, b_perr, b_busy;
    logic       b_r_clk, b_r_cd, b_r_dout, b_r_le, b_r_rt, b_r_reset;
    logic       b_r_din = 1'b0;

    tipi_rpi_master #(.CLK_DIV(4)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
        .cmd_ctrl(a_cmd_ctrl), .cmd_wdata(a_cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_parity_err(a_perr),
        .busy(a_busy), .r_clk(a_r_clk), .r_cd(a_r_cd), .r_dout(a_r_dout),
        .r_le(a_r_le), .r_rt(a_r_rt), .r_din(a_r_din), .r_reset(a_r_reset)
    );

    tipi_rpi_master #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_ctrl(b_cmd_ctrl), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_parity_err(b_perr),
        .busy(b_busy), .r_clk(b_r_clk), .r_cd(b_r_cd), .r_dout(b_r_dout),
        .r_le(b_r_le), .r_rt(b_r_rt), .r_din(b_r_din), .r_reset(b_r_reset)
    );

    // TI-side model for a: shift register clocked by r_clk, plus pulse history
    logic [7:0]  a_ti_sreg = 8'h00, a_ti_td = 8'h00, a_ti_tc = 8'h00;
    logic [7:0]  a_ti_rd = 8'h00, a_ti_rc = 8'h00;
    logic        a_bad_par = 1'b0;
    logic [15:0] a_le_hist = 16'h0, a_dout_hist = 16'h0;
    int          a_pcnt = 0;

    always @(posedge a_r_clk) begin
        a_pcnt      <= a_pcnt + 1;
        a_le_hist   <= {a_le_hist[14:0], a_r_le};
        a_dout_hist <= {a_dout_hist[14:0], a_r_dout};
        if (a_r_le) begin
            if (a_r_rt) begin
                a_ti_sreg <= a_r_cd ? a_ti_td : a_ti_tc;
            end else begin
                if (a_r_cd) a_ti_rd <= a_ti_sreg;
                else        a_ti_rc <= a_ti_sreg;
                a_r_din <= (^a_ti_sreg) ^ a_bad_par;
            end
        end else if (a_r_rt) begin
            a_r_din   <= a_ti_sreg[7];
            a_ti_sreg <= {a_ti_sreg[6:0], 1'b0};
        end else begin
            a_ti_sreg <= {a_ti_sreg[6:0], a_r_dout};
        end
    end

    // TI-side model for b: read path only
    logic [7:0] b_ti_sreg = 8'h00, b_ti_td = 8'h00;

    always @(posedge b_r_clk) begin
        if (b_r_le && b_r_rt) begin
            b_ti_sreg <= b_ti_td;
        end else if (b_r_rt) begin
            b_r_din   <= b_ti_sreg[7];
            b_ti_sreg <= {b_ti_sreg[6:0], 1'b0};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command on instance a; lat = edges from acceptance to rsp_valid
    task automatic run_a(input logic w, input logic c, input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        a_cmd_valid = 1'b1;
        a_cmd_write = w;
        a_cmd_ctrl  = c;
        a_cmd_wdata = d;
        n = 0;
        while (!a_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        a_cmd_write = ~w;
        a_cmd_ctrl  = ~c;
        a_cmd_wdata = ~d;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (a_rsp_valid) break;
            if (lat > 1000) begin
                lat = -1;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        int   n;
        int   base;
        logic saw_v, saw_rdy;

        a_reset = 1'b1; a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_ctrl = 1'b0;
        a_cmd_wdata = 8'h00; a_r_reset = 1'b1;
        b_reset = 1'b1; b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_ctrl = 1'b0;
        b_cmd_wdata = 8'h00; b_r_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("reset_outs", 32'({a_r_clk, a_r_le, a_r_dout, a_r_rt, a_r_cd, a_busy, a_rsp_valid, a_perr}), 32'h0);
        chk("reset_rdata", 32'(a_rsp_rdata), 32'h00);
        chk("reset_ready", 32'(a_cmd_ready), 32'h1);

        // write RD 8'hA5
        run_a(1'b1, 1'b0, 8'hA5, lat);
        chk("wr_a5_latency", 32'(lat), 32'd77);
        chk("wr_a5_rt_cd", 32'({a_r_rt, a_r_cd}), 32'b01);
        chk("wr_a5_dout_seq", 32'(a_dout_hist[8:1]), 32'hA5);
        chk("wr_a5_le_seq", 32'(a_le_hist[8:0]), 32'h001);
        chk("wr_a5_ti_rd", 32'(a_ti_rd), 32'hA5);
        chk("wr_a5_perr", 32'(a_perr), 32'h0);
        chk("wr_a5_rclk_low", 32'({a_r_clk, a_r_le}), 32'h0);
        @(negedge clk);
        chk("wr_a5_after", 32'({a_cmd_ready, a_rsp_valid, a_busy}), 32'b100);

        // read TC loaded with 8'h3C
        a_ti_tc = 8'h3C;
        run_a(1'b0, 1'b1, 8'h00, lat);
        chk("rd_tc_latency", 32'(lat), 32'd77);
        chk("rd_tc_rdata", 32'(a_rsp_rdata), 32'h3C);
        chk("rd_tc_rt_cd", 32'({a_r_rt, a_r_cd}), 32'b10);
        chk("rd_tc_le_seq", 32'(a_le_hist[8:0]), 32'h100);

        // control write 8'h07 with a corrupted parity echo, then a good write
        a_bad_par = 1'b1;
        run_a(1'b1, 1'b1, 8'h07, lat);
        chk("wr_07_perr", 32'(a_perr), 32'h1);
        chk("wr_07_ti_rc", 32'(a_ti_rc), 32'h07);
        repeat (5) @(negedge clk);
        chk("perr_hold", 32'(a_perr), 32'h1);
        a_bad_par = 1'b0;
        run_a(1'b1, 1'b0, 8'h5A, lat);
        chk("wr_5a_perr_clear", 32'(a_perr), 32'h0);
        chk("wr_5a_ti_rd", 32'(a_ti_rd), 32'h5A);

        // back-to-back reads of TD with cmd_valid held high
        a_ti_td = 8'hFF;
        @(negedge clk);
        a_cmd_valid = 1'b1;
        a_cmd_write = 1'b0;
        a_cmd_ctrl  = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_seen", 32'(a_rsp_valid), 32'h1);
        chk("b2b_first_rdata", 32'(a_rsp_rdata), 32'hFF);
        a_ti_td = 8'h00;
        @(negedge clk);
        chk("b2b_ready_after_done", 32'({a_cmd_ready, a_rsp_valid}), 32'b10);
        @(negedge clk);
        chk("b2b_accepted", 32'({a_busy, a_cmd_ready}), 32'b10);
        n = 1;
        while (!a_rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        a_cmd_valid = 1'b0;
        chk("b2b_second_latency", 32'(n), 32'd77);
        chk("b2b_second_rdata", 32'(a_rsp_rdata), 32'h00);

        // r_reset low at shift pulse 4 of a write
        @(negedge clk);
        @(negedge clk);
        base = a_pcnt;
        a_cmd_valid = 1'b1;
        a_cmd_write = 1'b1;
        a_cmd_ctrl  = 1'b0;
        a_cmd_wdata = 8'hC3;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        n = 0;
        while (a_pcnt < base + 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_pulse4", 32'(a_pcnt - base), 32'd4);
        a_r_reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({a_busy, a_r_clk, a_r_le, a_r_dout, a_cmd_ready}), 32'h0);
        saw_v   = 1'b0;
        saw_rdy = 1'b0;
        repeat (60) begin
            @(negedge clk);
            saw_v   = saw_v | a_rsp_valid;
            saw_rdy = saw_rdy | a_cmd_ready;
        end
        chk("abort_no_rsp", 32'({saw_v, saw_rdy}), 32'h0);
        chk("abort_rdata_kept", 32'(a_rsp_rdata), 32'h00);
        a_r_reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_again", 32'(a_cmd_ready), 32'h1);

        // CLK_DIV=1: read TD 8'h81
        b_ti_td = 8'h81;
        @(negedge clk);
        b_cmd_valid = 1'b1;
        b_cmd_write = 1'b0;
        b_cmd_ctrl  = 1'b0;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (b_rsp_valid || lat > 500) break;
        end
        chk("div1_latency", 32'(lat), 32'd20);
        chk("div1_rdata", 32'(b_rsp_rdata), 32'h81);

        // CLK_DIV=1: synchronous reset during the LOAD pulse
        @(negedge clk);
        b_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        n = 0;
        while (!b_r_le && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("div1_load_seen", 32'({b_r_le, b_r_rt}), 32'b11);
        b_reset = 1'b1;
        @(negedge clk);
        chk("div1_reset_outs", 32'({b_r_clk, b_r_le, b_r_dout, b_r_rt, b_r_cd, b_busy, b_rsp_valid, b_perr}), 32'h0);
        chk("div1_reset_rdata", 32'(b_rsp_rdata), 32'h00);
        b_reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
